bcd_to_bin: RTL

Sequential BCD-to-binary converter using reverse double-dabble: shift right, then subtract 3 from any BCD digit >= 8. It takes a packed multi-digit BCD value (default two digits, 00..99) and returns the binary equivalent. Used wherever a BCD value (setpoint entry, display-side value) must return to binary arithmetic. It is the decode counterpart of the temperature path's binary-to-BCD converter.

---
 rtl/bcd_to_bin_pkg.sv | 20 ++
 rtl/bcd_to_bin_if.sv | 27 ++
 rtl/bcd_digit_adjust.sv | 14 +
 rtl/bcd_to_bin.sv | 113 +++++++++++
 4 files changed

// File: rtl/bcd_to_bin_pkg.sv
// rtl/bcd_to_bin_pkg.sv - shared state encoding and digit constants for the BCD-to-binary converter
// Purpose: FSM state type, BCD digit limits and the reverse double-dabble adjust constants.
// Ports: none (package).
package bcd_to_bin_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_ADJUST = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
    localparam logic [3:0] ADJ_THRESH    = 4'd8;
    localparam logic [3:0] ADJ_SUB       = 4'd3;

    function automatic logic digit_ok(input logic [3:0] d);
        return d <= BCD_MAX_DIGIT;
    endfunction

endpackage

// File: rtl/bcd_to_bin_if.sv
// rtl/bcd_to_bin_if.sv - request/result bundle between a requester and the BCD-to-binary converter
// Purpose: groups the control, operand and result signals of bcd_to_bin.
// Signals: enable, start, bcd_in (requester -> converter);
//          busy, done, err, bin_out (converter -> requester).
// Modports: master = requester side, slave = converter side.
interface bcd_to_bin_if #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
);
    logic                  enable;
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [BIN_W-1:0]      bin_out;

    modport master (
        output enable, start, bcd_in,
        input  busy, done, err, bin_out
    );

    modport slave (
        input  enable, start, bcd_in,
        output busy, done, err, bin_out
    );
endinterface

// File: rtl/bcd_digit_adjust.sv
// rtl/bcd_digit_adjust.sv - single-digit correction step of reverse double-dabble
// Purpose: a BCD digit that reached 8 or more after a right shift came from a
//          tens borrow of 10 (shifted to 5); subtracting 3 restores 16-weight binary.
// Ports: i_digit (4b in), o_digit (4b out) = i_digit >= 8 ? i_digit - 3 : i_digit.
module bcd_digit_adjust
    import bcd_to_bin_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= ADJ_THRESH) ? (i_digit - ADJ_SUB) : i_digit;

endmodule

// File: rtl/bcd_to_bin.sv
// rtl/bcd_to_bin.sv - sequential BCD-to-binary converter using reverse double-dabble
// Purpose: converts a packed DIGITS-digit BCD operand to BIN_W-bit binary in
//          BIN_W shifts interleaved with BIN_W-1 digit-adjust steps.
// Ports: clk (rising edge), reset (async, active low),
//        bus (slave): enable, start, bcd_in in; busy, done, err, bin_out out.
module bcd_to_bin
    import bcd_to_bin_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic          clk,
    input  logic          reset,
    bcd_to_bin_if.slave   bus
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int CAT_W  = BCD_W + BIN_W;
    localparam int ITER_W = $clog2(BIN_W + 1);
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(BIN_W - 1);

    state_t              r_state;
    logic [BCD_W-1:0]    r_bcd_sr;
    logic [BIN_W-1:0]    r_bin_sr;
    logic [ITER_W-1:0]   r_iter;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic [BIN_W-1:0]    r_bin_out;

    logic                w_in_valid;
    logic [CAT_W-1:0]    w_shift;
    logic [BCD_W-1:0]    w_bcd_adj;

    always_comb begin
        w_in_valid = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!digit_ok(bus.bcd_in[4*i +: 4])) begin
                w_in_valid = 1'b0;
            end
        end
    end

    // The BCD register's LSB falls into the binary register's MSB each shift.
    assign w_shift = {r_bcd_sr, r_bin_sr} >> 1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .i_digit (r_bcd_sr[4*g +: 4]),
            .o_digit (w_bcd_adj[4*g +: 4])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_bcd_sr  <= '0;
            r_bin_sr  <= '0;
            r_iter    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_bin_out <= '0;
        end else if (bus.enable) begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (w_in_valid) begin
                            r_bcd_sr <= bus.bcd_in;
                            r_bin_sr <= '0;
                            r_iter   <= '0;
                            r_err    <= 1'b0;
                            r_busy   <= 1'b1;
                            r_state  <= ST_SHIFT;
                        end else begin
                            r_bin_out <= '0;
                            r_err     <= 1'b1;
                            r_done    <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_bcd_sr <= w_shift[CAT_W-1:BIN_W];
                    r_bin_sr <= w_shift[BIN_W-1:0];
                    r_iter   <= r_iter + 1'b1;
                    if (r_iter == LAST_ITER) begin
                        r_bin_out <= w_shift[BIN_W-1:0];
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_state <= ST_ADJUST;
                    end
                end
                ST_ADJUST: begin
                    r_bcd_sr <= w_bcd_adj;
                    r_state  <= ST_SHIFT;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.err     = r_err;
    assign bus.bin_out = r_bin_out;

endmodule
